// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite types for the command master
package ahb_pkg;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ahb_cmd_t;

  // Encoded as {aph, dph} so each bit reads directly as a phase-valid flag.
  typedef enum logic [1:0] {
    PH_IDLE      = 2'b00,
    PH_DATA      = 2'b01,
    PH_ADDR      = 2'b10,
    PH_ADDR_DATA = 2'b11
  } phase_t;

endpackage

// File: rtl/ahb_cmd_fifo.sv
// rtl/ahb_cmd_fifo.sv - synchronous command FIFO, head entry visible on dout
module ahb_cmd_fifo
  import ahb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  ahb_cmd_t      din,
  input  logic          pop,
  output ahb_cmd_t      dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  ahb_cmd_t          mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ahb_cmd_master.sv
// rtl/ahb_cmd_master.sv - command stream to AHB-Lite single transfers with in-order responses
module ahb_cmd_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W = ahb_pkg::ADDR_W,
  parameter int DATA_W = ahb_pkg::DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [1:0]        HTRANS,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  output logic              busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  ahb_cmd_t          cmd_in;
  ahb_cmd_t          head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              pop;

  phase_t            state_q;
  phase_t            state_d;
  logic              aph;
  logic              dph;
  logic [DATA_W-1:0] aph_wdata;
  logic              dph_write;

  assign cmd_in    = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready = !fifo_full;

  ahb_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (cmd_valid),
    .din   (cmd_in),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign aph    = state_q[1];
  assign dph    = state_q[0];
  assign HTRANS = aph ? NONSEQ : IDLE;
  assign busy   = (fifo_count != '0) || aph || dph;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= PH_IDLE;
    else          state_q <= state_d;
  end

  // The address phase retires into the data phase; a new address phase starts
  // whenever the FIFO has something to offer.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    if (HREADY) begin
      pop     = !fifo_empty;
      state_d = phase_t'({!fifo_empty, aph});
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
      aph_wdata <= '0;
      dph_write <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (HREADY) begin
        dph_write <= HWRITE;
        HWDATA    <= (aph && HWRITE) ? aph_wdata : '0;
        if (!fifo_empty) begin
          HADDR     <= head.addr;
          HWRITE    <= head.write;
          aph_wdata <= head.wdata;
        end
        if (dph) begin
          rsp_valid <= 1'b1;
          rsp_write <= dph_write;
          rsp_rdata <= dph_write ? '0 : HRDATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_cmd_master.sv
// tb/tb_ahb_cmd_master.sv - self-checking bench with zero/variable-wait memory slave and scoreboard
module tb_ahb_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [20:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic        rsp_write;
  logic [7:0]  rsp_rdata;
  logic [20:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [7:0]  HWDATA;
  logic [7:0]  HRDATA;
  logic        HREADY;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int run_len = 0;
  int max_run = 0;
  int rsp_count = 0;

  logic [8:0]  expq [$];
  logic [7:0]  rmem [32];

  logic [7:0]  smem [32];
  bit          mem_inited = 1'b0;
  logic        s_dph;
  logic        s_w;
  logic [20:0] s_a;

  always #5 HCLK = ~HCLK;

  ahb_cmd_master dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .HADDR     (HADDR),
    .HWRITE    (HWRITE),
    .HTRANS    (HTRANS),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .busy      (busy)
  );

  // Memory slave: latches the address phase, completes the data phase on HREADY.
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s_dph <= 1'b0;
      if (!mem_inited) begin
        for (int i = 0; i < 32; i++) smem[i] <= 8'(8'h40 + i);
        mem_inited <= 1'b1;
      end
    end else if (HREADY) begin
      if (s_dph && s_w) smem[s_a[4:0]] <= HWDATA;
      s_dph <= (HTRANS == 2'b10);
      s_a   <= HADDR;
      s_w   <= HWRITE;
    end
  end

  assign HRDATA = smem[s_a[4:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: commands complete in acceptance order against a flat memory.
  task automatic model_push(input logic w, input logic [4:0] a, input logic [7:0] d);
    if (w) begin
      rmem[a] = d;
      expq.push_back({1'b1, 8'h00});
    end else begin
      expq.push_back({1'b0, rmem[a]});
    end
  endtask

  task automatic tick(output bit acc);
    bit          stalled;
    logic [20:0] p_addr;
    logic        p_write;
    logic [1:0]  p_trans;
    logic [7:0]  p_wdata;
    logic [8:0]  e;
    acc     = cmd_valid && cmd_ready && HRESETn;
    stalled = !HREADY && HRESETn;
    p_addr  = HADDR;
    p_write = HWRITE;
    p_trans = HTRANS;
    p_wdata = HWDATA;
    @(posedge HCLK);
    if (acc) model_push(cmd_write, cmd_addr[4:0], cmd_wdata);
    @(negedge HCLK);
    if (HRESETn) begin
      if (stalled) begin
        chk("stall_haddr", 32'(HADDR), 32'(p_addr));
        chk("stall_hwrite", 32'(HWRITE), 32'(p_write));
        chk("stall_htrans", 32'(HTRANS), 32'(p_trans));
        chk("stall_hwdata", 32'(HWDATA), 32'(p_wdata));
        chk("stall_rsp", 32'(rsp_valid), 0);
      end
      if (rsp_valid) begin
        rsp_count++;
        if (expq.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 0);
        end else begin
          e = expq.pop_front();
          chk("rsp_write", 32'(rsp_write), 32'(e[8]));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e[7:0]));
        end
      end
      if (HTRANS == 2'b10) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
    end
  endtask

  task automatic send(input logic w, input logic [4:0] a, input logic [7:0] d);
    bit acc;
    int n;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = 21'(a);
    cmd_wdata = d;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 40) begin
      tick(acc);
      n++;
    end
    if (!acc) chk("send_timeout", 32'(cmd_ready), 1);
  endtask

  task automatic drain(input string tag);
    bit acc;
    int n;
    cmd_valid = 1'b0;
    n = 0;
    while ((busy || expq.size() != 0) && n < 60) begin
      tick(acc);
      n++;
    end
    chk(tag, 32'(busy || (expq.size() != 0)), 0);
  endtask

  initial begin
    bit          acc;
    int          base;
    logic [20:0] q_addr;
    logic [1:0]  q_trans;
    logic [7:0]  q_wdata;

    for (int i = 0; i < 32; i++) rmem[i] = 8'(8'h40 + i);
    HRESETn   = 1'b0;
    HREADY    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    #1;
    chk("rst_htrans", 32'(HTRANS), 0);
    chk("rst_haddr", 32'(HADDR), 0);
    chk("rst_hwrite", 32'(HWRITE), 0);
    chk("rst_hwdata", 32'(HWDATA), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_write", 32'(rsp_write), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick(acc);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);

    // Single write latency.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 21'd3; cmd_wdata = 8'hA5;
    tick(acc);
    chk("lat_accept", 32'(acc), 1);
    cmd_valid = 1'b0;
    chk("lat_no_bypass", 32'(HTRANS), 0);
    tick(acc);
    chk("lat_nonseq", 32'(HTRANS), 2);
    chk("lat_haddr", 32'(HADDR), 3);
    chk("lat_hwrite", 32'(HWRITE), 1);
    tick(acc);
    chk("lat_hwdata", 32'(HWDATA), 32'hA5);
    chk("lat_rsp_early", 32'(rsp_valid), 0);
    tick(acc);
    chk("lat_rsp_valid", 32'(rsp_valid), 1);
    chk("lat_rsp_write", 32'(rsp_write), 1);
    drain("lat_drain");
    chk("lat_mem3", 32'(smem[3]), 32'hA5);

    // Back-to-back writes then reads.
    run_len = 0; max_run = 0; base = rsp_count;
    for (int i = 0; i < 5; i++) send(1'b1, 5'(i), 8'(8'h10 + i));
    for (int i = 0; i < 5; i++) send(1'b0, 5'(i), 8'h00);
    drain("b2b_drain");
    chk("b2b_nonseq_run", 32'(max_run), 10);
    chk("b2b_rsp_count", 32'(rsp_count - base), 10);

    // Fill with the bus stalled.
    HREADY = 1'b0; base = rsp_count;
    for (int i = 0; i < 4; i++) send(1'b1, 5'(8 + i), 8'(8'hC0 + i));
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 21'd12; cmd_wdata = 8'hC4;
    tick(acc);
    tick(acc);
    chk("full_ready", 32'(cmd_ready), 0);
    chk("full_blocked", 32'(acc), 0);
    chk("full_busy", 32'(busy), 1);
    HREADY = 1'b1;
    send(1'b1, 5'd12, 8'hC4);
    send(1'b0, 5'd9, 8'h00);
    drain("full_drain");
    chk("full_rsp_count", 32'(rsp_count - base), 6);

    // Stall during ADDR_DATA.
    send(1'b1, 5'd20, 8'h71);
    send(1'b1, 5'd21, 8'h72);
    send(1'b0, 5'd20, 8'h00);
    cmd_valid = 1'b0;
    HREADY = 1'b0;
    q_addr = HADDR; q_trans = HTRANS; q_wdata = HWDATA;
    for (int i = 0; i < 3; i++) tick(acc);
    chk("stall3_haddr", 32'(HADDR), 32'(q_addr));
    chk("stall3_htrans", 32'(HTRANS), 32'(q_trans));
    chk("stall3_hwdata", 32'(HWDATA), 32'(q_wdata));
    HREADY = 1'b1;
    drain("stall_drain");

    // Reset in the middle of a read burst.
    send(1'b0, 5'd5, 8'h00);
    send(1'b0, 5'd6, 8'h00);
    send(1'b0, 5'd7, 8'h00);
    #2;
    HRESETn = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("mid_rst_htrans", 32'(HTRANS), 0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    expq.delete();
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick(acc);
    chk("post_rst_ready", 32'(cmd_ready), 1);
    chk("post_rst_busy", 32'(busy), 0);

    // Read, overwrite, read back.
    send(1'b0, 5'd2, 8'h00);
    send(1'b1, 5'd2, 8'h5C);
    send(1'b0, 5'd2, 8'h00);
    drain("rw_drain");
    chk("rw_mem2", 32'(smem[2]), 32'h5C);

    // Random traffic with random wait states.
    for (int c = 0; c < 300; c++) begin
      HREADY = ($urandom_range(0, 3) != 0);
      if (!cmd_valid || acc) begin
        cmd_valid = ($urandom_range(0, 2) != 0);
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = 21'($urandom_range(0, 31));
        cmd_wdata = 8'($urandom);
      end
      tick(acc);
    end
    HREADY = 1'b1;
    drain("rand_drain");
    for (int i = 0; i < 32; i++) chk("final_mem", 32'(smem[i]), 32'(rmem[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
